// File: rtl/mips_fetch_stage_pkg.sv
// mips_fetch_stage_pkg
// Shared definitions for the MIPS-lite instruction-fetch stage:
//   - opcode constants (bits 31:26 of an instruction word)
//   - fetch FSM state enum
//   - IF/ID record layout {valid, ir, pc}, also used for the pend buffer
//   - is_halt() helper used wherever a fetched word is classified
package mips_fetch_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BZ    = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_JR    = 6'd16;
    localparam logic [5:0] OP_HALT  = 6'd17;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
    } ifid_t;

    function automatic logic is_halt(input logic [5:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// mips_fetch_stage_if
// Instruction-memory bus between the fetch stage (master) and the
// byte-addressed instruction memory (slave).
//   imem_req   master->slave  fetch request
//   imem_addr  master->slave  word-aligned byte address
//   imem_ack   slave->master  read data valid this cycle
//   imem_rdata slave->master  big-endian word, byte[addr] on bits 31:24
//
// Handshake: the master raises imem_req and holds imem_req/imem_addr stable
// until a cycle in which imem_ack=1; that cycle completes the transfer and
// imem_rdata is valid in it. imem_ack may come in the same cycle the request
// first appears (zero-wait). imem_ack is only meaningful while imem_req=1.
// On reset the master may drop imem_req before the ack; the memory must
// simply forget that request.
interface mips_fetch_stage_if #(
    parameter int MEM_ADDR_W = 12
) ();
    logic                  imem_req;
    logic [MEM_ADDR_W-1:0] imem_addr;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);
endinterface

// File: rtl/mips_fetch_stage_pend_buffer.sv
// fetch_pend_buffer
// One-entry skid buffer holding a fetched {ir, pc} while decode stalls.
//   clk, reset  clock, synchronous active-high reset (empties the entry)
//   load_i      capture ir_i/pc_i and mark the entry valid
//   clear_i     empty the entry (wins over load_i)
//   ir_i, pc_i  word and its PC to capture
//   pend_o      current entry {valid, ir, pc}
module fetch_pend_buffer
    import mips_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] pc_i,
    output ifid_t       pend_o
);

    ifid_t pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clear_i) begin
            pend_d.valid = 1'b0;
        end else if (load_i) begin
            pend_d.valid = 1'b1;
            pend_d.ir    = ir_i;
            pend_d.pc    = pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
// Instruction fetch for the MIPS-lite pipeline. Owns the PC, fetches words
// over the imem bus, fills the IF/ID register, parks one word in a pend
// buffer during a decode stall, follows execute redirects and stops after
// a HALT opcode.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem                instruction-memory bus (master side)
//   stall_i             decode load-use stall, holds a valid IF/ID
//   redirect_i          taken branch / JR from execute
//   redirect_pc_i       redirect target (bits 1:0 forced to 00)
//   ifid_valid_o/ir/pc  IF/ID register contents
//   fetch_halted_o      HALT fetched, no further requests
//   state_o             current fetch FSM state (debug)
// Build option MIPS_FETCH_STATS_EN adds fetch_count_o and redirect_count_o,
// saturating 32-bit counters of accepted words and redirect cycles.
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'd0,
    parameter int          MEM_ADDR_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    mips_fetch_stage_if.master imem,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               ifid_valid_o,
    output logic [31:0]        ifid_ir_o,
    output logic [31:0]        ifid_pc_o,
    output logic               fetch_halted_o,
    output fetch_state_e       state_o
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_count_o,
    output logic [31:0]        redirect_count_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    // Redirect target parked while DRAIN finishes the old request; pc_q keeps
    // the old address so imem_addr stays stable until the ack.
    logic [31:0]  tgt_q, tgt_d;
    ifid_t        ifid_q, ifid_d;
    ifid_t        pend;
    logic         pend_load, pend_clear;
    logic         req;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
    // Gated by reset so the request drops immediately when reset asserts.
    assign req = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && !reset;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q[MEM_ADDR_W-1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ifid_d     = ifid_q;
        pend_load  = 1'b0;
        pend_clear = 1'b0;

        // IF/ID holds only while stalled with a live instruction; otherwise
        // it becomes a bubble unless something below loads it.
        if (!stall_i || !ifid_q.valid) begin
            ifid_d.valid = 1'b0;
        end

        if (redirect_i) begin
            ifid_d.valid = 1'b0;
            pend_clear   = 1'b1;
            if (req && !imem.imem_ack) begin
                state_d = ST_DRAIN;
                tgt_d   = redirect_tgt;
            end else begin
                state_d = ST_FETCH;
                pc_d    = redirect_tgt;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (!stall_i || !ifid_q.valid) begin
                            ifid_d.valid = 1'b1;
                            ifid_d.ir    = imem.imem_rdata;
                            ifid_d.pc    = pc_q;
                            state_d = is_halt(imem.imem_rdata[31:26]) ? ST_HALTED : ST_FETCH;
                        end else begin
                            pend_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_ack) begin
                        state_d = ST_FETCH;
                        pc_d    = tgt_q;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        ifid_d     = pend;
                        pend_clear = 1'b1;
                        state_d    = is_halt(pend.ir[31:26]) ? ST_HALTED : ST_FETCH;
                    end
                end
                default: begin
                    // ST_HALTED: only redirect (above) or reset leaves.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_RESET;
            tgt_q   <= PC_RESET;
            ifid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ifid_q  <= ifid_d;
        end
    end

    fetch_pend_buffer u_pend (
        .clk     (clk),
        .reset   (reset),
        .load_i  (pend_load),
        .clear_i (pend_clear),
        .ir_i    (imem.imem_rdata),
        .pc_i    (pc_q),
        .pend_o  (pend)
    );

    assign ifid_valid_o   = ifid_q.valid;
    assign ifid_ir_o      = ifid_q.ir;
    assign ifid_pc_o      = ifid_q.pc;
    assign fetch_halted_o = (state_q == ST_HALTED);
    assign state_o        = state_q;

`ifdef MIPS_FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;
    logic        accept;

    // A word counts when acked in FETCH and not thrown away by a redirect.
    assign accept = (state_q == ST_FETCH) && req && imem.imem_ack && !redirect_i;

    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (accept && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (redirect_i && (redirect_count_q != 32'hFFFF_FFFF)) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count_o    = fetch_count_q;
    assign redirect_count_o = redirect_count_q;
`endif

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage of the MIPS-lite pipeline with forwarding; it sits directly upstream of decode and feeds the IF/ID register that decode consumes. It owns the PC and issues word fetches to the byte-addressed instruction memory through a req/ack handshake. A one-entry pending buffer absorbs a returned word while decode holds a load-use stall. It also handles branch/JR redirects from execute and stops fetching after a HALT opcode.

## Interface
Parameters:
- PC_RESET, 32'd0, PC value loaded on reset
- MEM_ADDR_W, 12, byte-address width of instruction memory (4096 bytes)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  MEM_ADDR_W  word-aligned byte address = pc[MEM_ADDR_W-1:0]
- imem_ack  in  1  data valid; may be asserted the same cycle as imem_req
- imem_rdata  in  32  big-endian word: byte[addr] on bits 31:24
- stall_i  in  1  decode load-use stall: hold IF/ID
- redirect_i  in  1  taken BZ/BEQ or JR resolved in execute
- redirect_pc_i  in  32  redirect target; bits 1:0 ignored (forced 00)
- ifid_valid_o  out  1  IF/ID holds a live instruction
- ifid_ir_o  out  32  instruction word (Ir)
- ifid_pc_o  out  32  PC of that instruction
- fetch_halted_o  out  1  HALT fetched, fetching stopped

## Operation
- States: FETCH, DRAIN, HOLD, HALTED.
- FETCH: imem_req=1, imem_addr=pc, stable until ack. On ack, the word goes to IF/ID if IF/ID is empty or stall_i=0; otherwise it goes to pend (-> HOLD). pc <= pc+4 (mod 2^32). If word[31:26]==17 (HALT), next state is HALTED.
- HOLD: imem_req=0. When stall_i drops, pend moves to IF/ID, pend is cleared, and the state returns to FETCH (or HALTED if pend holds HALT).
- IF/ID update when stall_i=0: pend if pend is valid, else the acked word, else bubble (ifid_valid_o <= 0). When stall_i=1 and IF/ID is valid, IF/ID holds. stall_i with IF/ID empty is ignored.
- Redirect has highest priority in every state:
  - pc <= {redirect_pc_i[31:2],2'b00}; IF/ID and pend are invalidated.
  - If a request is outstanding without ack in the redirect cycle, go to DRAIN. imem_req stays high on the old address, and the acked data is discarded; then go to FETCH.
  - If ack coincides with redirect, the data is discarded and the state goes straight to FETCH.
- HALTED: imem_req=0, fetch_halted_o=1. Redirect returns to FETCH, because HALT fetched in a branch shadow is speculative. Only reset or redirect leaves HALTED.
- imem_addr wraps at 2^MEM_ADDR_W because only the low bits are driven.

## Timing
- Reset values:
  - pc=PC_RESET, state=FETCH, pend empty.
  - ifid_valid_o=0, ifid_ir_o=0, ifid_pc_o=0, fetch_halted_o=0.
  - imem_req=0 during reset, then 1 in the first cycle after reset deasserts.
- Zero-wait memory (ack same cycle as req): the instruction is visible in IF/ID the next cycle; throughput is 1 per cycle.
- Redirect in cycle N: ifid_valid_o=0 and imem_addr=target in cycle N+1 (unless DRAIN).
- Simultaneous redirect+stall: redirect wins. Simultaneous stall release + pend valid: pend wins, and no new request issues that cycle.
- Reset mid-request abandons the outstanding request. The memory must tolerate req dropping before ack.

## Configuration
- MIPS_FETCH_STATS_EN defined: adds fetch_count_o (32) and redirect_count_o (32).
  - fetch_count_o increments on each accepted non-discarded word.
  - redirect_count_o increments on each redirect_i cycle.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Not defined: both ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package:
  - opcode constants (HALT=6'd17, plus the rest of the opcode set)
  - fetch state enum typedef
  - IF/ID struct typedef {valid, ir, pc}
- Optional sub-module: fetch_pend_buffer, a one-entry skid holding {ir, pc}. All else is flat.

## Test plan
- Zero-wait memory, words at 0,4,8, no stall -> ifid_pc_o = 0,4,8 on consecutive cycles, ifid_valid_o continuous.
- Ack delayed 3 cycles on address 0x10 -> imem_addr stays 0x10 and imem_req stays high for 3 cycles; IF/ID loads 1 cycle after ack.
- IF/ID valid at 0x20, stall_i high 2 cycles, ack for 0x24 -> state HOLD, imem_req=0; after release ifid_pc_o=0x24, then 0x28 fetched.
- Redirect to 0x103 while request to 0x30 is outstanding -> DRAIN, 0x30 data discarded, next imem_addr=0x100, ifid_valid_o=0 in between.
- HALT word (0x44000000) at 0x40 -> fetch_halted_o=1, imem_req=0 thereafter; redirect to 0x50 -> fetching resumes at 0x50.
- Reset asserted mid-DRAIN -> pc=PC_RESET, all outputs at reset values, fetch resumes at PC_RESET.
